// File: rtl/traffic_logger.sv
// Hourly vehicle-count histogram with an hour-boundary snapshot and
// READ/WRITE request handshake toward the rank calculator.
module traffic_logger #(
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter int unsigned CNT_W       = 10,
  parameter int unsigned NUM_HOURS   = 24
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             VEH_DET,
  input  logic [4:0]       HOUR,
  input  logic [5:0]       MINUTE,
  input  logic [5:0]       SECOND,
  input  logic [1:0]       OP2,
  output logic [1:0]       OP1,
  output logic [CNT_W-1:0] TRAFFIC_DATA [NUM_HOURS],
  output logic [CNT_W-1:0] CUR_COUNT,
  output logic             BUSY,
  output logic             DONE,
  output logic             TIMEOUT_ERR
);

  localparam int unsigned      WAIT_W    = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [4:0]       LAST_HOUR = 5'(NUM_HOURS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [1:0]       OP_IDLE   = 2'b00;
  localparam logic [1:0]       OP_READ   = 2'b01;
  localparam logic [1:0]       OP_WRITE  = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK} state_e;

  state_e            state_q, state_d;
  logic              pending_q, pending_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              take_snap, err_c;

  logic              veh_q;
  logic [4:0]        prev_hour_q;
  logic [CNT_W-1:0]  bins_q   [NUM_HOURS];
  logic [CNT_W-1:0]  bins_d   [NUM_HOURS];
  logic [CNT_W-1:0]  snap_q   [NUM_HOURS];
  logic [CNT_W-1:0]  snap_src [NUM_HOURS];

  logic [1:0]        op1_q, op1_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              count_en, hour_ok, hr_evt, rollover, op2_write;
  logic              unused_status;

  assign unused_status = ^{MINUTE, SECOND};

  assign count_en  = VEH_DET & ~veh_q;
  assign hour_ok   = (HOUR <= LAST_HOUR);
  assign hr_evt    = (HOUR != prev_hour_q);
  assign rollover  = hr_evt && (prev_hour_q == LAST_HOUR) && (HOUR == 5'd0);
  assign op2_write = (OP2 == OP_WRITE);

  // Live bins: day rollover clears first, so a same-cycle detection lands in hour 0.
  always_comb begin
    bins_d = bins_q;
    if (rollover) begin
      bins_d = '{default: '0};
    end
    if (count_en && hour_ok && (bins_d[HOUR] != CNT_MAX)) begin
      bins_d[HOUR] = bins_d[HOUR] + CNT_W'(1);
    end
  end

  // On an hour change the detection belongs to the new hour, so the snapshot excludes it.
  always_comb begin
    if (hr_evt) begin
      snap_src = bins_q;
    end else begin
      snap_src = bins_d;
    end
  end

  assign CUR_COUNT = hour_ok ? bins_q[HOUR] : '0;

  always_ff @(posedge CLK) begin : state_reg
    if (RST) begin
      state_q   <= S_IDLE;
      pending_q <= 1'b0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      wait_q    <= wait_d;
    end
  end

  always_comb begin : next_state
    state_d   = state_q;
    pending_d = pending_q;
    wait_d    = wait_q;
    take_snap = 1'b0;
    err_c     = 1'b0;
    case (state_q)
      S_IDLE: begin
        wait_d = '0;
        if (hr_evt || pending_q) begin
          if (op2_write) begin
            // Previous WRITE still asserted: hold the request until it drops.
            if (hr_evt) begin
              err_c     = pending_q;
              pending_d = 1'b1;
            end
          end else begin
            take_snap = 1'b1;
            pending_d = 1'b0;
            state_d   = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (op2_write) begin
          state_d = S_ACK;
        end else if (wait_q == WAIT_W'(TIMEOUT_CYC - 1)) begin
          err_c   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
        if (hr_evt) begin
          if (pending_q) err_c = 1'b1;
          pending_d = 1'b1;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
        if (hr_evt) begin
          if (pending_q) err_c = 1'b1;
          pending_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin : out_comb
    op1_d  = OP_IDLE;
    busy_d = 1'b0;
    done_d = 1'b0;
    err_d  = err_c;
    case (state_d)
      S_REQ: begin
        op1_d  = OP_READ;
        busy_d = 1'b1;
      end
      S_ACK:   done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin : datapath_reg
    veh_q       <= VEH_DET;
    prev_hour_q <= HOUR;
    if (RST) begin
      bins_q <= '{default: '0};
      snap_q <= '{default: '0};
      op1_q  <= OP_IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      bins_q <= bins_d;
      if (take_snap) snap_q <= snap_src;
      op1_q  <= op1_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  assign OP1          = op1_q;
  assign BUSY         = busy_q;
  assign DONE         = done_q;
  assign TIMEOUT_ERR  = err_q;
  assign TRAFFIC_DATA = snap_q;

endmodule

// File: tb/tb_traffic_logger.sv
// Randomized bench for traffic_logger against a histogram-level reference model.
module tb_traffic_logger;

  logic       clk;
  logic       rst;
  logic       veh_det;
  logic [4:0] hour;
  logic [5:0] minute;
  logic [5:0] second;
  logic [1:0] op2;
  logic [1:0] op1;
  logic [9:0] traffic_data [24];
  logic [9:0] cur_count;
  logic       busy;
  logic       done;
  logic       timeout_err;

  int n_tests = 0;
  int n_fail  = 0;
  int live     [24];
  int snap_exp [24];
  logic [4:0] prev_h;

  traffic_logger dut (
    .CLK          (clk),
    .RST          (rst),
    .VEH_DET      (veh_det),
    .HOUR         (hour),
    .MINUTE       (minute),
    .SECOND       (second),
    .OP2          (op2),
    .OP1          (op1),
    .TRAFFIC_DATA (traffic_data),
    .CUR_COUNT    (cur_count),
    .BUSY         (busy),
    .DONE         (done),
    .TIMEOUT_ERR  (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    minute = 6'($urandom_range(0, 59));
    second = 6'($urandom_range(0, 59));
  endtask

  function automatic int live_at(input logic [4:0] h);
    if (h < 5'd24) return live[h];
    return 0;
  endfunction

  function automatic int snap_mism();
    int m = 0;
    for (int i = 0; i < 24; i++) if (int'(traffic_data[i]) != snap_exp[i]) m++;
    return m;
  endfunction

  task automatic clear_live();
    for (int i = 0; i < 24; i++) live[i] = 0;
  endtask

  // One detector pulse; the bin saturates at 1023 and invalid hours are ignored.
  task automatic pulse();
    veh_det = 1'b1;
    step();
    veh_det = 1'b0;
    if (hour < 5'd24) live[hour] = (live[hour] >= 1023) ? 1023 : live[hour] + 1;
    step();
  endtask

  // Rank-calculator responder: WRITE on the delay-th READ cycle (0 = never).
  task automatic serve(input int delay, output int reads, output bit dn, output bit er);
    reads = 0;
    dn    = 1'b0;
    er    = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (op1 == 2'b01) begin
        reads++;
        check("req_busy", busy, 1);
        check("snap_stable", snap_mism(), 0);
        if (reads == delay) op2 = 2'b10;
      end
      if (done) begin
        dn  = 1'b1;
        op2 = 2'b00;
        check("ack_busy", busy, 0);
      end
      if (timeout_err) er = 1'b1;
      if (op1 != 2'b01 && (dn || er)) break;
      step();
    end
  endtask

  task automatic check_serve(input int delay, input int reads, input bit dn, input bit er);
    if (delay == 0) begin
      check("to_reads", reads, 16);
      check("to_err", er, 1);
      check("to_nodone", dn, 0);
    end else begin
      check("req_reads", reads, delay);
      check("req_done", dn, 1);
      check("req_noerr", er, 0);
      step();
      check("done_one_cycle", done, 0);
    end
  endtask

  task automatic hour_req(input logic [4:0] h, input int delay);
    int reads;
    bit dn, er;
    hour = h;
    #1;
    check("cur_count_pre", cur_count, live_at(h));
    snap_exp = live;
    if (prev_h == 5'd23 && h == 5'd0) clear_live();
    prev_h = h;
    step();
    check("req_op1", op1, 2'b01);
    serve(delay, reads, dn, er);
    check_serve(delay, reads, dn, er);
  endtask

  initial begin
    int n, n23, reads;
    bit dn, er;
    logic [4:0] h;

    rst = 1'b1; veh_det = 1'b0; hour = 5'd5; op2 = 2'b00;
    minute = '0; second = '0;
    prev_h = 5'd5;
    clear_live();
    for (int i = 0; i < 24; i++) snap_exp[i] = 0;
    step(); step();
    rst = 1'b0;
    step();
    check("rst_op1", op1, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", timeout_err, 0);
    check("rst_cur", cur_count, 0);
    check("rst_snap", snap_mism(), 0);

    n = $urandom_range(2, 6);
    repeat (n) pulse();
    check("count_h5", cur_count, live[5]);
    check("op1_idle_count", op1, 0);
    hour_req(5'd6, $urandom_range(1, 4));
    check("snap_h5", traffic_data[5], n);

    hour_req(5'd7, $urandom_range(1, 3));
    n = $urandom_range(1024, 1100);
    repeat (n) pulse();
    check("sat_model", cur_count, live[7]);
    check("sat_1023", cur_count, 1023);

    hour_req(5'd8, $urandom_range(1, 3));
    repeat ($urandom_range(1, 5)) pulse();
    hour_req(5'd9, 0);
    repeat (3) step();
    check("to_idle", op1, 0);
    check("to_snap_kept", snap_mism(), 0);
    hour_req(5'd8, $urandom_range(1, 3));
    check("snap_h7_sat", traffic_data[7], 1023);

    repeat (5) begin
      h = 5'($urandom_range(1, 22));
      if (h == prev_h) h = 5'((h % 22) + 1);
      hour_req(h, $urandom_range(1, 5));
      repeat ($urandom_range(0, 4)) pulse();
    end

    hour_req(5'd27, 2);
    repeat (2) pulse();
    check("bad_hour_cur", cur_count, 0);

    // Day rollover with a detection in the rollover cycle.
    hour_req(5'd23, 1);
    n23 = $urandom_range(1, 6);
    repeat (n23) pulse();
    hour = 5'd0; veh_det = 1'b1;
    snap_exp = live;
    clear_live();
    live[0] = 1;
    prev_h = 5'd0;
    step();
    veh_det = 1'b0;
    check("roll_op1", op1, 2'b01);
    serve(1, reads, dn, er);
    check_serve(1, reads, dn, er);
    check("roll_snap23", traffic_data[23], n23);
    check("roll_bin0", cur_count, 1);

    // Stalled REQ: first hour change pends, second overflows.
    hour = 5'd10; #1;
    check("pend_cur10", cur_count, live[10]);
    snap_exp = live; prev_h = 5'd10;
    step();
    check("pend_op1", op1, 2'b01);
    check("pend_snap_a", snap_mism(), 0);
    repeat ($urandom_range(1, 2)) pulse();
    hour = 5'd11; prev_h = 5'd11;
    step();
    check("pend_first_noerr", timeout_err, 0);
    repeat ($urandom_range(1, 2)) pulse();
    hour = 5'd12; prev_h = 5'd12;
    step();
    check("pend_overflow", timeout_err, 1);
    check("pend_still_req", op1, 2'b01);
    check("pend_snap_held", snap_mism(), 0);
    op2 = 2'b10;
    step();
    check("pend_ack_done", done, 1);
    check("pend_ack_op1", op1, 0);
    op2 = 2'b00;
    step();
    check("no_b2b_op1", op1, 0);
    check("no_b2b_done", done, 0);
    snap_exp = live;
    step();
    check("pend_serviced", op1, 2'b01);
    n = $urandom_range(1, 3);
    serve(n, reads, dn, er);
    check_serve(n, reads, dn, er);

    // Reset in the middle of a request.
    hour = 5'd13; prev_h = 5'd13;
    snap_exp = live;
    step();
    check("mid_op1", op1, 2'b01);
    step();
    rst = 1'b1;
    step();
    clear_live();
    for (int i = 0; i < 24; i++) snap_exp[i] = 0;
    check("mid_rst_op1", op1, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_cur", cur_count, 0);
    check("mid_rst_snap", snap_mism(), 0);
    rst = 1'b0;
    repeat (3) begin
      step();
      check("post_rst_done", done, 0);
      check("post_rst_op1", op1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
